// File: rtl/io_uart_port.sv
// io_uart_port: one flag-driven serial channel, TX on fgo fall, RX into inpr_in; even parity when IO_UART_PARITY_EN is defined.
// TX completes 10 (11 with parity) bit times after the trigger; RX delivers at mid stop bit, no backpressure (fgi=1 drops the byte).
module io_uart_port #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       fgo,
   input  logic [7:0] outr,
   output logic       fgo_bsy,
   input  logic       fgi,
   output logic [7:0] inpr_in,
   output logic       fgi_bsy,
   output logic       txd,
   input  logic       rxd,
   input  logic       err_clr,
   output logic       rx_ovr,
   output logic       rx_ferr,
   output logic       rx_perr
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] C_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] C_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_START = 3'd1,
      S_DATA  = 3'd2,
`ifdef IO_UART_PARITY_EN
      S_PAR   = 3'd4,
`endif
      S_STOP  = 3'd3
   } state_t;

   // ---------------- TX ----------------
   state_t        r_tx_st;
   state_t        w_tx_nxt;
   logic [CW-1:0] r_tx_cnt;
   logic [2:0]    r_tx_bit;
   logic [7:0]    r_tx_sh;
   logic          r_fgo_d;
   logic          r_fgo_bsy;
   logic          w_tx_trig;
   logic          w_tx_tick;
   logic          w_txd;
`ifdef IO_UART_PARITY_EN
   logic          r_tx_par;
`endif

   assign w_tx_trig = (r_tx_st == S_IDLE) && r_fgo_d && !fgo;
   assign w_tx_tick = (r_tx_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_tx_st <= S_IDLE;
      else        r_tx_st <= w_tx_nxt;
   end

   always_comb begin
      w_tx_nxt = r_tx_st;
      case (r_tx_st)
         S_IDLE:  if (w_tx_trig) w_tx_nxt = S_START;
         S_START: if (w_tx_tick) w_tx_nxt = S_DATA;
         S_DATA: begin
            if (w_tx_tick && r_tx_bit == 3'd7) begin
`ifdef IO_UART_PARITY_EN
               w_tx_nxt = S_PAR;
`else
               w_tx_nxt = S_STOP;
`endif
            end
         end
`ifdef IO_UART_PARITY_EN
         S_PAR:   if (w_tx_tick) w_tx_nxt = S_STOP;
`endif
         S_STOP:  if (w_tx_tick) w_tx_nxt = S_IDLE;
         default: w_tx_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_txd = 1'b1;
      case (r_tx_st)
         S_START: w_txd = 1'b0;
         S_DATA:  w_txd = r_tx_sh[0];
`ifdef IO_UART_PARITY_EN
         S_PAR:   w_txd = r_tx_par;
`endif
         default: w_txd = 1'b1;
      endcase
   end

   // fgo_d resets to 1 so a CPU already holding fgo low after reset counts as an OUT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fgo_d   <= 1'b1;
         r_fgo_bsy <= 1'b0;
         r_tx_cnt  <= '0;
         r_tx_bit  <= '0;
         r_tx_sh   <= '0;
`ifdef IO_UART_PARITY_EN
         r_tx_par  <= 1'b0;
`endif
      end else begin
         r_fgo_d   <= fgo;
         r_fgo_bsy <= (r_tx_st == S_STOP) && w_tx_tick;
         if (w_tx_trig) begin
            r_tx_sh  <= outr;
            r_tx_cnt <= C_BIT_LAST;
            r_tx_bit <= '0;
`ifdef IO_UART_PARITY_EN
            r_tx_par <= ^outr;
`endif
         end else if (r_tx_st != S_IDLE) begin
            if (w_tx_tick) begin
               r_tx_cnt <= C_BIT_LAST;
               if (r_tx_st == S_DATA) begin
                  r_tx_sh  <= r_tx_sh >> 1;
                  r_tx_bit <= r_tx_bit + 3'd1;
               end
            end else begin
               r_tx_cnt <= r_tx_cnt - 1'b1;
            end
         end
      end
   end

   assign txd     = w_txd;
   assign fgo_bsy = r_fgo_bsy;

   // ---------------- RX ----------------
   state_t        r_rx_st;
   state_t        w_rx_nxt;
   logic          r_rx_s1;
   logic          r_rx_s2;
   logic          r_rx_d;
   logic [CW-1:0] r_rx_cnt;
   logic [2:0]    r_rx_bit;
   logic [7:0]    r_rx_sh;
   logic [7:0]    r_inpr;
   logic          r_fgi_bsy;
   logic          r_rx_ovr;
   logic          r_rx_ferr;
   logic          w_rx_start;
   logic          w_rx_tick;
   logic          w_stop_smp;
   logic          w_ferr_set;
   logic          w_ovr_set;
   logic          w_rx_ok;
`ifdef IO_UART_PARITY_EN
   logic          r_rx_pbad;
   logic          r_rx_perr;
   logic          w_perr_set;
`endif

   assign w_rx_start = (r_rx_st == S_IDLE) && r_rx_d && !r_rx_s2;
   assign w_rx_tick  = (r_rx_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_rx_st <= S_IDLE;
      else        r_rx_st <= w_rx_nxt;
   end

   always_comb begin
      w_rx_nxt = r_rx_st;
      case (r_rx_st)
         S_IDLE:  if (w_rx_start) w_rx_nxt = S_START;
         S_START: if (w_rx_tick) w_rx_nxt = r_rx_s2 ? S_IDLE : S_DATA;
         S_DATA: begin
            if (w_rx_tick && r_rx_bit == 3'd7) begin
`ifdef IO_UART_PARITY_EN
               w_rx_nxt = S_PAR;
`else
               w_rx_nxt = S_STOP;
`endif
            end
         end
`ifdef IO_UART_PARITY_EN
         S_PAR:   if (w_rx_tick) w_rx_nxt = S_STOP;
`endif
         S_STOP:  if (w_rx_tick) w_rx_nxt = S_IDLE;
         default: w_rx_nxt = S_IDLE;
      endcase
   end

   // Every check is resolved on the mid-stop sample so all failing flags land together.
   always_comb begin
      w_stop_smp = (r_rx_st == S_STOP) && w_rx_tick;
      w_ferr_set = w_stop_smp && !r_rx_s2;
      w_ovr_set  = w_stop_smp && r_rx_s2 && fgi;
`ifdef IO_UART_PARITY_EN
      w_perr_set = w_stop_smp && r_rx_pbad;
      w_rx_ok    = w_stop_smp && r_rx_s2 && !fgi && !r_rx_pbad;
`else
      w_rx_ok    = w_stop_smp && r_rx_s2 && !fgi;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_d    <= 1'b1;
         r_rx_cnt  <= '0;
         r_rx_bit  <= '0;
         r_rx_sh   <= '0;
         r_inpr    <= 8'h00;
         r_fgi_bsy <= 1'b0;
         r_rx_ovr  <= 1'b0;
         r_rx_ferr <= 1'b0;
`ifdef IO_UART_PARITY_EN
         r_rx_pbad <= 1'b0;
         r_rx_perr <= 1'b0;
`endif
      end else begin
         r_rx_s1   <= rxd;
         r_rx_s2   <= r_rx_s1;
         r_rx_d    <= r_rx_s2;
         r_fgi_bsy <= w_rx_ok;
         if (w_rx_ok) r_inpr <= r_rx_sh;
         if (w_rx_start) begin
            r_rx_cnt <= C_HALF_LAST;
            r_rx_bit <= '0;
         end else if (r_rx_st != S_IDLE) begin
            if (w_rx_tick) begin
               r_rx_cnt <= C_BIT_LAST;
               if (r_rx_st == S_DATA) begin
                  r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                  r_rx_bit <= r_rx_bit + 3'd1;
               end
`ifdef IO_UART_PARITY_EN
               if (r_rx_st == S_PAR) r_rx_pbad <= r_rx_s2 ^ (^r_rx_sh);
`endif
            end else begin
               r_rx_cnt <= r_rx_cnt - 1'b1;
            end
         end
         if (w_ovr_set)    r_rx_ovr  <= 1'b1;
         else if (err_clr) r_rx_ovr  <= 1'b0;
         if (w_ferr_set)   r_rx_ferr <= 1'b1;
         else if (err_clr) r_rx_ferr <= 1'b0;
`ifdef IO_UART_PARITY_EN
         if (w_perr_set)   r_rx_perr <= 1'b1;
         else if (err_clr) r_rx_perr <= 1'b0;
`endif
      end
   end

   assign inpr_in = r_inpr;
   assign fgi_bsy = r_fgi_bsy;
   assign rx_ovr  = r_rx_ovr;
   assign rx_ferr = r_rx_ferr;
`ifdef IO_UART_PARITY_EN
   assign rx_perr = r_rx_perr;
`else
   assign rx_perr = 1'b0;
`endif

endmodule
